// File: rtl/speed_meter_pkg.sv
// speed_meter_pkg: default constants and saturating step arithmetic for the speed_meter_mc family.
package speed_meter_pkg;

  localparam int unsigned DEF_STEP    = 1920;
  localparam int unsigned DEF_WIN_LEN = 30719;

  // Adds or subtracts one step from an acc_w-bit unsigned accumulator carried in 32 bits.
  // Returns {sat, value}: sat is set whenever the result had to be clamped to 0 or 2^acc_w-1.
  // When inc and dec are both set they cancel, exactly as when neither is set.
  function automatic logic [32:0] sat_step(
    input logic [31:0] acc,
    input logic        inc,
    input logic        dec,
    input logic [31:0] step,
    input int unsigned acc_w
  );
    logic [32:0] max_v;
    logic [32:0] sum;
    max_v    = (33'd1 << acc_w) - 33'd1;
    sum      = {1'b0, acc} + {1'b0, step};
    sat_step = {1'b0, acc};
    if (inc && !dec) begin
      if (sum > max_v) sat_step = {1'b1, max_v[31:0]};
      else             sat_step = sum;
    end else if (dec && !inc) begin
      if (acc < step) sat_step = {1'b1, 32'd0};
      else            sat_step = {1'b0, acc - step};
    end
  endfunction

endpackage

// File: rtl/speed_meter_mc_if.sv
// speed_meter_mc_if: event inputs, window programming and published results of speed_meter_mc.
// With SPEED_METER_PEAK_EN defined it also carries peak_clr and peak_out.
interface speed_meter_mc_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned ACC_W = 18,
  parameter int unsigned TMR_W = 16
);

  logic [N_CH-1:0]       inc;
  logic [N_CH-1:0]       dec;
  logic [TMR_W-1:0]      win_len;
  logic                  win_load;
  logic [N_CH*ACC_W-1:0] d_out;
  logic                  valid_out;
  logic [N_CH-1:0]       sat_out;
  logic [TMR_W-1:0]      win_active;
`ifdef SPEED_METER_PEAK_EN
  logic                  peak_clr;
  logic [N_CH*ACC_W-1:0] peak_out;
`endif

  // valid_out is a one-cycle publish strobe with no ready and no back-pressure: d_out, sat_out
  // (and peak_out) change only on the edge that raises valid_out and hold until the next strobe.
  // inc, dec, win_load and peak_clr are single-cycle pulses sampled on every clk edge.
`ifdef SPEED_METER_PEAK_EN
  modport master (
    output inc, dec, win_len, win_load, peak_clr,
    input  d_out, valid_out, sat_out, win_active, peak_out
  );
  modport slave (
    input  inc, dec, win_len, win_load, peak_clr,
    output d_out, valid_out, sat_out, win_active, peak_out
  );
`else
  modport master (
    output inc, dec, win_len, win_load,
    input  d_out, valid_out, sat_out, win_active
  );
  modport slave (
    input  inc, dec, win_len, win_load,
    output d_out, valid_out, sat_out, win_active
  );
`endif

endinterface

// File: rtl/speed_meter_chan.sv
// speed_meter_chan: one channel's saturating window accumulator, sticky saturation flag and result.
// With SPEED_METER_PEAK_EN defined it also keeps the largest published result.
module speed_meter_chan
  import speed_meter_pkg::*;
#(
  parameter int unsigned ACC_W = 18,
  parameter int unsigned STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             tc,
`ifdef SPEED_METER_PEAK_EN
  input  logic             peak_clr,
  output logic [ACC_W-1:0] peak,
`endif
  output logic [ACC_W-1:0] result,
  output logic             sat
);

  logic [ACC_W-1:0]  acc;
  logic              sticky;
  logic [32:0]       nxt;
  logic [ACC_W-1:0]  nxt_val;
  logic              nxt_sat;
  logic [31-ACC_W:0] unused_hi;

  assign nxt       = sat_step(32'(acc), inc, dec, 32'(STEP), ACC_W);
  assign nxt_val   = nxt[ACC_W-1:0];
  assign nxt_sat   = nxt[32];
  assign unused_hi = nxt[31:ACC_W];

  // The terminal cycle publishes the value including that cycle's own event, so nothing is lost
  // across the window boundary; the new window then starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      sticky <= 1'b0;
      result <= '0;
      sat    <= 1'b0;
    end else if (tc) begin
      result <= nxt_val;
      sat    <= sticky | nxt_sat;
      acc    <= '0;
      sticky <= 1'b0;
    end else begin
      acc    <= nxt_val;
      sticky <= sticky | nxt_sat;
    end
  end

`ifdef SPEED_METER_PEAK_EN
  // A clear that lands on the terminal cycle restarts the peak from the fresh result, not from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak <= '0;
    end else if (tc) begin
      if (peak_clr || (nxt_val > peak)) peak <= nxt_val;
    end else if (peak_clr) begin
      peak <= '0;
    end
  end
`endif

endmodule

// File: rtl/speed_meter_mc.sv
// speed_meter_mc: N_CH-channel windowed event-rate meter; all channels publish together at window end.
// Optional peak tracking (peak_clr / peak_out) is built when SPEED_METER_PEAK_EN is defined.
module speed_meter_mc
  import speed_meter_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned ACC_W       = 18,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned TMR_W       = 16,
  parameter int unsigned WIN_DEFAULT = DEF_WIN_LEN
) (
  input logic             clk,
  input logic             reset,
  speed_meter_mc_if.slave bus
);

  localparam logic [TMR_W-1:0] WIN_RST = TMR_W'(WIN_DEFAULT);
  localparam logic [TMR_W-1:0] WIN_MIN = TMR_W'(1);

  logic [TMR_W-1:0]      timer;
  logic [TMR_W-1:0]      win_active;
  logic [TMR_W-1:0]      win_pending;
  logic                  win_pend_flag;
  logic                  valid_q;
  logic                  tc;
  logic [TMR_W-1:0]      win_len_clamped;
  logic [N_CH*ACC_W-1:0] d_flat;
  logic [N_CH-1:0]       sat_flat;

  assign tc              = (timer == win_active);
  assign win_len_clamped = (bus.win_len == '0) ? WIN_MIN : bus.win_len;

  // A load in the terminal cycle lands in win_pending after the old pending value has been
  // promoted, so it takes effect one window later; repeated loads simply overwrite.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer         <= '0;
      win_active    <= WIN_RST;
      win_pending   <= WIN_RST;
      win_pend_flag <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= tc;
      timer   <= tc ? '0 : timer + TMR_W'(1);
      if (tc && win_pend_flag) begin
        win_active    <= win_pending;
        win_pend_flag <= 1'b0;
      end
      if (bus.win_load) begin
        win_pending   <= win_len_clamped;
        win_pend_flag <= 1'b1;
      end
    end
  end

`ifdef SPEED_METER_PEAK_EN
  logic [N_CH*ACC_W-1:0] peak_flat;
  assign bus.peak_out = peak_flat;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    speed_meter_chan #(
      .ACC_W (ACC_W),
      .STEP  (STEP)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .inc      (bus.inc[k]),
      .dec      (bus.dec[k]),
      .tc       (tc),
`ifdef SPEED_METER_PEAK_EN
      .peak_clr (bus.peak_clr),
      .peak     (peak_flat[k*ACC_W +: ACC_W]),
`endif
      .result   (d_flat[k*ACC_W +: ACC_W]),
      .sat      (sat_flat[k])
    );
  end

  assign bus.d_out      = d_flat;
  assign bus.sat_out    = sat_flat;
  assign bus.valid_out  = valid_q;
  assign bus.win_active = win_active;

endmodule

// File: tb/tb_speed_meter_mc.sv
// tb_speed_meter_mc: randomized event streams for speed_meter_mc checked against a window-level integer model.
`timescale 1ns/1ps
module tb_speed_meter_mc;

  localparam int N_CH    = 4;
  localparam int ACC_W   = 18;
  localparam int STEP    = 1920;
  localparam int MAX_V   = (1 << ACC_W) - 1;
  localparam int WIN_DEF = 30719;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  speed_meter_mc_if bus ();

  speed_meter_mc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: integer accumulators, absolute cycle number of the next window end.
  int   m_cyc, m_tc_at, m_win, m_pend_val;
  bit   m_pend, m_valid;
  int   m_acc [N_CH];
  bit   m_stk [N_CH];
  int   m_res [N_CH];
  bit   m_sat [N_CH];
  logic [3:0] s_inc [0:WIN_DEF];
  logic [3:0] s_dec [0:WIN_DEF];

  function automatic logic [ACC_W-1:0] dout(input int k);
    return bus.d_out[k*ACC_W +: ACC_W];
  endfunction

  function automatic logic [3:0] rnd_mask(input int one_in);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < N_CH; k++) m[k] = ($urandom_range(0, one_in - 1) == 0);
    return m;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_win = WIN_DEF; m_tc_at = WIN_DEF;
    m_pend = 1'b0; m_pend_val = WIN_DEF; m_valid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      m_acc[k] = 0; m_stk[k] = 1'b0; m_res[k] = 0; m_sat[k] = 1'b0;
    end
  endtask

  // Applies the currently driven inputs for one clock, advances the model, then clears pulses.
  task automatic clock_cycle();
    logic [3:0]  i_inc, i_dec;
    logic        i_ld;
    logic [15:0] i_len;
    bit          tc;
    i_inc = bus.inc; i_dec = bus.dec; i_ld = bus.win_load; i_len = bus.win_len;
    @(posedge clk);
    tc = (m_cyc == m_tc_at);
    for (int k = 0; k < N_CH; k++) begin
      if (i_inc[k] && !i_dec[k]) begin
        m_acc[k] += STEP;
        if (m_acc[k] > MAX_V) begin m_acc[k] = MAX_V; m_stk[k] = 1'b1; end
      end else if (i_dec[k] && !i_inc[k]) begin
        m_acc[k] -= STEP;
        if (m_acc[k] < 0) begin m_acc[k] = 0; m_stk[k] = 1'b1; end
      end
      if (tc) begin
        m_res[k] = m_acc[k]; m_sat[k] = m_stk[k];
        m_acc[k] = 0; m_stk[k] = 1'b0;
      end
    end
    m_valid = tc;
    if (tc) begin
      if (m_pend) begin m_win = m_pend_val; m_pend = 1'b0; end
      m_tc_at = m_cyc + m_win + 1;
    end
    if (i_ld) begin
      m_pend_val = (i_len == 16'd0) ? 1 : int'(i_len);
      m_pend = 1'b1;
    end
    m_cyc++;
    #1;
    bus.inc = '0; bus.dec = '0; bus.win_load = 1'b0;
`ifdef SPEED_METER_PEAK_EN
    bus.peak_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    vectors++;
    if (bus.d_out !== '0) begin miscompares++; $display("FAIL reset_dout got=%h exp=0", bus.d_out); end
    vectors++;
    if (bus.sat_out !== 4'b0) begin miscompares++; $display("FAIL reset_sat got=%b exp=0", bus.sat_out); end
    vectors++;
    if (bus.win_active !== 16'(WIN_DEF)) begin miscompares++; $display("FAIL reset_win got=%0d exp=%0d", bus.win_active, WIN_DEF); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_default_window();
    int exp_v [N_CH] = '{19200, 5760, 262143, 0};
    int ld_at;
    for (int c = 0; c <= WIN_DEF; c++) begin s_inc[c] = '0; s_dec[c] = '0; end
    for (int i = 0; i < 10; i++)  s_inc[i*3000 + int'($urandom_range(0, 2999))][0] = 1'b1;
    for (int i = 0; i < 5; i++)   s_inc[i*1000 + int'($urandom_range(0, 999))][1] = 1'b1;
    for (int i = 0; i < 2; i++)   s_dec[10000 + i*1000 + int'($urandom_range(0, 999))][1] = 1'b1;
    ld_at = 20000 + int'($urandom_range(0, 999));
    s_inc[ld_at][1] = 1'b1;
    s_dec[ld_at][1] = 1'b1;
    for (int i = 0; i < 137; i++) s_inc[i*200 + int'($urandom_range(0, 199))][2] = 1'b1;
    s_dec[$urandom_range(0, 29999)][3] = 1'b1;
    ld_at = int'($urandom_range(1000, 29000));
    for (int c = 0; c <= WIN_DEF; c++) begin
      bus.inc = s_inc[c]; bus.dec = s_dec[c];
      if (c == ld_at) begin bus.win_len = 16'd99; bus.win_load = 1'b1; end
      clock_cycle();
      vectors++;
      if (bus.valid_out !== m_valid) begin
        miscompares++; $display("FAIL dflt_valid cyc=%0d got=%b exp=%b", c, bus.valid_out, m_valid);
      end
      if (c == WIN_DEF - 1) begin
        vectors++;
        if (bus.win_active !== 16'(WIN_DEF)) begin
          miscompares++; $display("FAIL dflt_win_hold got=%0d exp=%0d", bus.win_active, WIN_DEF);
        end
      end
    end
    vectors++;
    if (bus.valid_out !== 1'b1) begin miscompares++; $display("FAIL dflt_strobe_30720 got=%b exp=1", bus.valid_out); end
    for (int k = 0; k < N_CH; k++) begin
      vectors++;
      if (dout(k) !== 18'(exp_v[k])) begin
        miscompares++; $display("FAIL dflt_dout ch%0d got=%0d exp=%0d", k, dout(k), exp_v[k]);
      end
    end
    vectors++;
    if (bus.sat_out !== 4'b1100) begin miscompares++; $display("FAIL dflt_sat got=%b exp=1100", bus.sat_out); end
    vectors++;
    if (bus.win_active !== 16'd99) begin miscompares++; $display("FAIL dflt_win_new got=%0d exp=99", bus.win_active); end
  endtask

  task automatic test_short_windows();
    int one2;
    one2 = int'($urandom_range(0, 98));
    for (int c = 0; c < 500; c++) begin
      bus.inc = rnd_mask(8); bus.dec = rnd_mask(8);
      if (c < 200) begin
        bus.inc[0] = 1'b0; bus.dec[0] = 1'b0;
        bus.inc[2] = (c == one2); bus.dec[2] = 1'b0;
      end
      if (c == 99) bus.inc[0] = 1'b1;
      if (c == 299) begin bus.win_len = 16'd49; bus.win_load = 1'b1; end
      clock_cycle();
      vectors++;
      if (bus.valid_out !== m_valid) begin
        miscompares++; $display("FAIL short_valid cyc=%0d got=%b exp=%b", c, bus.valid_out, m_valid);
      end
      if (m_valid) begin
        for (int k = 0; k < N_CH; k++) begin
          vectors++;
          if (dout(k) !== 18'(m_res[k]) || bus.sat_out[k] !== m_sat[k]) begin
            miscompares++;
            $display("FAIL short_result cyc=%0d ch%0d got=%0d/%b exp=%0d/%b", c, k, dout(k), bus.sat_out[k], m_res[k], m_sat[k]);
          end
        end
        vectors++;
        if (bus.win_active !== 16'(m_win)) begin
          miscompares++; $display("FAIL short_win cyc=%0d got=%0d exp=%0d", c, bus.win_active, m_win);
        end
      end
      if (c == 99) begin
        vectors++;
        if (dout(0) !== 18'd1920 || dout(2) !== 18'd1920 || bus.sat_out[2] !== 1'b0) begin
          miscompares++;
          $display("FAIL tc_pulse_and_recover got ch0=%0d ch2=%0d sat2=%b exp 1920 1920 0", dout(0), dout(2), bus.sat_out[2]);
        end
      end
      if (c == 199) begin
        vectors++;
        if (dout(0) !== 18'd0) begin miscompares++; $display("FAIL after_tc_restart got=%0d exp=0", dout(0)); end
      end
    end
  endtask

  task automatic test_min_window();
    int n_valid;
    n_valid = 0;
    for (int c = 0; c < 60; c++) begin
      bus.inc = 4'b1010 | rnd_mask(4);
      bus.dec = rnd_mask(4) & 4'b0101;
      if (c == 10) begin bus.win_len = 16'd30; bus.win_load = 1'b1; end
      if (c == 20) begin bus.win_len = 16'd0;  bus.win_load = 1'b1; end
      clock_cycle();
      vectors++;
      if (bus.valid_out !== m_valid) begin
        miscompares++; $display("FAIL min_valid cyc=%0d got=%b exp=%b", c, bus.valid_out, m_valid);
      end
      if (m_valid) begin
        for (int k = 0; k < N_CH; k++) begin
          vectors++;
          if (dout(k) !== 18'(m_res[k]) || bus.sat_out[k] !== m_sat[k]) begin
            miscompares++;
            $display("FAIL min_result cyc=%0d ch%0d got=%0d/%b exp=%0d/%b", c, k, dout(k), bus.sat_out[k], m_res[k], m_sat[k]);
          end
        end
      end
      if (c >= 50 && bus.valid_out === 1'b1) n_valid++;
    end
    vectors++;
    if (bus.win_active !== 16'd1) begin miscompares++; $display("FAIL min_win_clamp got=%0d exp=1", bus.win_active); end
    vectors++;
    if (n_valid != 5) begin miscompares++; $display("FAIL min_period2 strobes got=%0d exp=5", n_valid); end
  endtask

  task automatic test_reset_mid_window();
    for (int c = 0; c < 502; c++) begin
      if (c < 2) bus.inc = 4'hF;
      else begin bus.inc = rnd_mask(16); bus.dec = rnd_mask(32); end
      if (c == 0)   begin bus.win_len = 16'd999; bus.win_load = 1'b1; end
      if (c == 300) begin bus.win_len = 16'd9;   bus.win_load = 1'b1; end
      clock_cycle();
      vectors++;
      if (bus.valid_out !== m_valid) begin
        miscompares++; $display("FAIL pre_rst_valid cyc=%0d got=%b exp=%b", c, bus.valid_out, m_valid);
      end
      if (c == 1) begin
        vectors++;
        if (dout(2) !== 18'(m_res[2])) begin miscompares++; $display("FAIL pre_rst_dout got=%0d exp=%0d", dout(2), m_res[2]); end
      end
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.d_out !== '0 || bus.sat_out !== 4'b0 || bus.valid_out !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_outputs got d=%h sat=%b v=%b exp 0", bus.d_out, bus.sat_out, bus.valid_out);
    end
    vectors++;
    if (bus.win_active !== 16'(WIN_DEF)) begin miscompares++; $display("FAIL async_reset_win got=%0d exp=%0d", bus.win_active, WIN_DEF); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c <= WIN_DEF; c++) begin
      bus.inc = rnd_mask(256); bus.dec = rnd_mask(512);
      clock_cycle();
      vectors++;
      if (bus.valid_out !== m_valid) begin
        miscompares++; $display("FAIL post_rst_valid cyc=%0d got=%b exp=%b", c, bus.valid_out, m_valid);
      end
    end
    vectors++;
    if (bus.valid_out !== 1'b1) begin miscompares++; $display("FAIL post_rst_strobe_30720 got=%b exp=1", bus.valid_out); end
    for (int k = 0; k < N_CH; k++) begin
      vectors++;
      if (dout(k) !== 18'(m_res[k]) || bus.sat_out[k] !== m_sat[k]) begin
        miscompares++;
        $display("FAIL post_rst_result ch%0d got=%0d/%b exp=%0d/%b", k, dout(k), bus.sat_out[k], m_res[k], m_sat[k]);
      end
    end
    vectors++;
    if (bus.win_active !== 16'(WIN_DEF)) begin miscompares++; $display("FAIL pending_cleared got=%0d exp=%0d", bus.win_active, WIN_DEF); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.inc      = '0;
    bus.dec      = '0;
    bus.win_len  = '0;
    bus.win_load = 1'b0;
`ifdef SPEED_METER_PEAK_EN
    bus.peak_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_default_window();
    test_short_windows();
    test_min_window();
    test_reset_mid_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/speed_meter_mc.md
Name: speed_meter_mc

Overview:
- Multi-channel successor of the single-channel 1 ms throughput meter.
- Each of N_CH channels accumulates a signed step per event pulse (increment or decrement) over a programmable window.
- Results for all channels are published simultaneously with a one-cycle valid strobe.
- Sits in the clk domain behind the modem's per-stream event detectors; pulses arrive already synchronised and stretched to one clk cycle.

Parameters:
- N_CH, 4, number of independent channels
- ACC_W, 18, accumulator and result width per channel (unsigned)
- STEP, 1920, amount added or subtracted per event
- TMR_W, 16, window timer width
- WIN_DEFAULT, 30719, reset window terminal count (1 ms at 30.72 MHz; period = value+1)

Ports:
- clk  in  1  30.72 MHz system clock
- reset  in  1  asynchronous, active-high reset
- inc  in  N_CH  per-channel increment pulse, 1 clk wide
- dec  in  N_CH  per-channel decrement pulse, 1 clk wide
- win_len  in  TMR_W  new window terminal count
- win_load  in  1  1-cycle strobe: capture win_len
- d_out  out  N_CH*ACC_W  published results, channel k at [k*ACC_W +: ACC_W]
- valid_out  out  1  1-cycle strobe, d_out updated
- sat_out  out  N_CH  per-channel flag: saturation occurred in the published window
- win_active  out  TMR_W  terminal count currently in use

Behaviour:
- Reset (async) clears:
  - timer, all accumulators, d_out, valid_out, sat_out and the pending-load flag;
  - win_active and win_pending are set to WIN_DEFAULT.
- Timer:
  - counts 0..win_active, wraps to 0;
  - the cycle with timer==win_active is the terminal cycle (TC).
- Per channel, per cycle:
  - inc&~dec: +STEP.
  - dec&~inc: -STEP.
  - both or neither: no change.
- Arithmetic is unsigned ACC_W with saturation:
  - clamps at 2^ACC_W-1 on overflow and at 0 on underflow;
  - any clamp sets that channel's sticky sat bit for the current window.
- At TC:
  - the channel's next value, including TC-cycle events, goes to its d_out slice;
  - the sticky sat bit goes to sat_out;
  - accumulator and sticky bit clear to 0;
  - valid_out = 1 in the following cycle only.
  - Latency: event at cycle t is visible on d_out at the first valid_out after t; no event is ever lost across a window boundary.
- Window programming:
  - win_load captures win_len into win_pending and sets the pending flag.
  - At the next TC, win_active <= win_pending and the pending flag clears.
  - win_load in the TC cycle itself is applied at the following TC.
  - win_len==0 is clamped to 1 on capture (minimum 2-cycle window).
  - Multiple loads within one window: the last one wins.
- d_out and sat_out hold between strobes.
- Reset mid-window discards partial counts; no valid_out is produced for the aborted window.

Optional Feature:
- SPEED_METER_PEAK_EN defined:
  - adds output peak_out (N_CH*ACC_W), updated at each TC to max(peak, result) per channel;
  - adds input peak_clr (1-cycle strobe) that zeroes all peaks;
  - peak_clr coinciding with TC loads the new result instead of 0;
  - reset zeroes peaks.
- Not defined: no peak ports, logic or registers exist.

Decomposition:
- Package speed_meter_pkg:
  - default constants (WIN_DEFAULT, STEP);
  - a saturating add/sub function taking (acc, inc, dec, step) and returning {sat, value}.
- Natural sub-module: speed_meter_chan. It holds one accumulator, the sticky sat bit and the result register, with the TC strobe as input. It is instantiated N_CH times via generate.
- Timer and window-load logic stay in the top.

Test Plan:
- Default window, channel 0 gets 10 inc pulses spread over the window, others idle → valid_out at cycle 30720 after reset release; d_out[ch0]=19200, others 0, sat_out=0.
- Channel 1: 5 inc and 2 dec, plus one cycle with inc&dec both high → d_out[ch1]=5760.
- Channel 2: 137 inc in one window (137*1920 > 262143) → d_out[ch2]=262143, sat_out[2]=1; next window with 1 inc → 1920, sat_out[2]=0.
- Channel 3: dec with accumulator 0 → stays 0, sat_out[3]=1.
- Pulse on ch0 exactly in the TC cycle → counted in the closing window's d_out; next window starts at 0.
- win_load with win_len=99 mid-window → the current window completes at 30719; subsequent valid_out strobes every 100 cycles; win_active=99. Then win_len=0 → period 2.
- Assert reset 500 cycles into a window with counts pending → all outputs 0 immediately; first valid_out 30720 cycles after release.
